// File: rtl/gaussian_blur_3x3.sv
// Streaming 3x3 Gaussian smoothing stage: FWFT FIFO in, FIFO out, one output per input pixel.
// Optional build macro GAUSSIAN_ROUND_EN selects round-half-up instead of truncation.
module gaussian_blur_3x3 #(
    parameter int WIDTH  = 720,
    parameter int HEIGHT = 540
) (
    input  logic       clock,
    input  logic       reset,
    output logic       in_rd_en,
    input  logic       in_empty,
    input  logic [7:0] in_dout,
    output logic       out_wr_en,
    input  logic       out_full,
    output logic [7:0] out_din
);

    localparam int DEPTH = 2 * WIDTH + 3;
    localparam int TOTAL = WIDTH * HEIGHT;
    localparam int CNT_W = $clog2(TOTAL + WIDTH + 1);
    localparam int COL_W = $clog2(WIDTH);
    localparam int ROW_W = $clog2(HEIGHT);

    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] RUN_LAST   = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(TOTAL + WIDTH);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(HEIGHT - 1);

`ifdef GAUSSIAN_ROUND_EN
    localparam logic [11:0] ROUND_BIAS = 12'd8;
`else
    localparam logic [11:0] ROUND_BIAS = 12'd0;
`endif

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       sr_q [DEPTH];
    logic [7:0]       sr_d [DEPTH];
    logic [CNT_W-1:0] in_count_q, in_count_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [7:0]       out_reg_q, out_reg_d;
    logic             out_valid_q, out_valid_d;

    logic             slot_free;
    logic             shift;
    logic             border;
    logic [11:0]      sum;
    logic [7:0]       blur;

    always_comb begin
        slot_free = ~out_valid_q | ~out_full;
        out_wr_en = out_valid_q & ~out_full;
        out_din   = out_reg_q;

        shift = 1'b0;
        case (state_q)
            S_FILL, S_RUN: shift = slot_free & ~in_empty;
            S_FLUSH:       shift = slot_free;
            default:       shift = 1'b0;
        endcase
        // Gated by reset so the pop strobe drops asynchronously while reset is held.
        in_rd_en = shift & (state_q != S_FLUSH) & reset;

        // Index 0 is the newest pixel; the window reads the post-shift contents.
        sr_d = sr_q;
        if (shift) begin
            sr_d[0] = (state_q == S_FLUSH) ? 8'h00 : in_dout;
            for (int k = 1; k < DEPTH; k++) begin
                sr_d[k] = sr_q[k-1];
            end
        end

        sum = 12'(sr_d[0]) + 12'(sr_d[2]) + 12'(sr_d[2*WIDTH]) + 12'(sr_d[2*WIDTH+2])
            + ((12'(sr_d[1]) + 12'(sr_d[WIDTH]) + 12'(sr_d[WIDTH+2]) + 12'(sr_d[2*WIDTH+1])) << 1)
            + (12'(sr_d[WIDTH+1]) << 2);

        border = (row_q == '0) || (row_q == ROW_LAST) || (col_q == '0) || (col_q == COL_LAST);
        blur   = border ? 8'h00 : 8'((sum + ROUND_BIAS) >> 4);

        state_d     = state_q;
        in_count_d  = in_count_q;
        row_d       = row_q;
        col_d       = col_q;
        out_reg_d   = out_reg_q;
        out_valid_d = out_valid_q;

        // A producing shift refills the slot even when the old value drains this cycle.
        if (shift && state_q != S_FILL) begin
            out_reg_d   = blur;
            out_valid_d = 1'b1;
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
                col_d = col_q + COL_W'(1);
            end
        end else if (out_wr_en) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_FILL: if (shift) begin
                in_count_d = in_count_q + CNT_W'(1);
                if (in_count_q == FILL_LAST) state_d = S_RUN;
            end
            S_RUN: if (shift) begin
                in_count_d = in_count_q + CNT_W'(1);
                if (in_count_q == RUN_LAST) state_d = S_FLUSH;
            end
            S_FLUSH: if (shift) begin
                if (in_count_q == FLUSH_LAST) begin
                    in_count_d = '0;
                    row_d      = '0;
                    col_d      = '0;
                    state_d    = S_FILL;
                end else begin
                    in_count_d = in_count_q + CNT_W'(1);
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_FILL;
            // NOTE: the window store is reset explicitly so a restarted frame never sees stale pixels.
            for (int k = 0; k < DEPTH; k++) begin
                sr_q[k] <= 8'h00;
            end
            in_count_q  <= '0;
            row_q       <= '0;
            col_q       <= '0;
            out_reg_q   <= 8'h00;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates keep every flop sampling the pre-edge values.
            state_q     <= state_d;
            sr_q        <= sr_d;
            in_count_q  <= in_count_d;
            row_q       <= row_d;
            col_q       <= col_d;
            out_reg_q   <= out_reg_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule
